prog_loader: RTL
================

// Module: prog_loader
// PURPOSE
//  Byte-stream program loader upstream of the one-cycle processor's instruction memory.
//  Accepts a framed byte stream (from the UART receiver), assembles 16-bit instruction words,
//  and writes them sequentially to imem via the processor's data/address/write-enable inputs.
//  Holds the processor (cpu_hold) while loading; reports done/error.
// PARAMETERS
//  ADDR_W     8      instruction memory address width
//  DATA_W     16     instruction word width (fixed 2 bytes/word)
//  BASE_ADDR  8'h00  first imem address written
// PORTS
//  clk           in   1       system clock, all logic on rising edge
//  rst_n         in   1       asynchronous active-low reset
//  start         in   1       1-cycle request to begin a load frame
//  rx_data       in   8       incoming byte
//  rx_valid      in   1       rx_data valid
//  rx_ready      out  1       loader accepts byte; transfer when rx_valid & rx_ready
//  imem_data     out  DATA_W  instruction word to imem
//  imem_addr     out  ADDR_W  imem write address
//  imem_we       out  1       imem write strobe, 1 cycle per word
//  cpu_hold      out  1       processor stall while busy
//  busy          out  1       frame in progress
//  done          out  1       frame completed OK; held until next start
//  error         out  1       frame failed; held until next start
//  words_loaded  out  ADDR_W+1 words written in current/last frame
// BEHAVIOUR
//  - Reset: all outputs 0; state IDLE; internal counters 0. Reset mid-frame aborts, no further writes.
//  - Frame: byte0 = word count N (0 means 2^ADDR_W), then N words, high byte first.
//  - States: IDLE -> CNT (on start) -> HI -> LO -> WR -> HI... ; after Nth WR -> DONE (or CHK).
//  - rx_ready=1 only in CNT, HI, LO, CHK; 0 in IDLE, WR, DONE, ERR. One byte per accepted handshake.
//  - WR: imem_we=1 exactly one cycle; imem_addr=BASE_ADDR+index (mod 2^ADDR_W), imem_data={hi,lo}
//    stable that cycle; imem_addr/imem_data hold last values otherwise. words_loaded increments in WR.
//  - Latency: imem_we asserts the cycle after the low byte is accepted.
//  - busy = cpu_hold = 1 in CNT..WR/CHK; deassert on the cycle state enters DONE/ERR.
//  - start ignored while busy; start in IDLE/DONE/ERR clears done, error, words_loaded, index.
//  - rx_valid while rx_ready=0: byte not consumed (upstream holds it); no data loss.
//  - Address wrap: N=256 writes BASE_ADDR..BASE_ADDR+255 modulo 256; no overflow error.
// CONFIGURATION
//  - LOADER_CHECKSUM_EN defined: after last word, state CHK takes one byte; must equal XOR of
//    all payload bytes (count byte excluded). Match -> DONE; mismatch -> ERR (error=1, done=0;
//    imem contents already written are left as-is, cpu_hold released).
//  - Not defined: no CHK state; after last WR go directly to DONE; error never asserts.
// STRUCTURE
//  - loader_defs.vh: state encodings (IDLE,CNT,HI,LO,WR,CHK,DONE,ERR), BYTES_PER_WORD=2.
//  - One sub-module: word_assembler (captures hi/lo bytes, outputs {hi,lo} and running XOR).
//  - Top: FSM, index/word counters, output registers.
// TESTING
//  - Reset: rst_n=0 mid-frame -> all outputs 0 immediately, no imem_we afterwards.
//  - start; bytes 02,48,10,4A,12 -> imem_we at addr 0 data 4810, addr 1 data 4A12; done=1, words_loaded=2.
//  - Backpressure: rx_valid held during WR -> byte not consumed until rx_ready=1; data order intact.
//  - Count 00 with 256 words -> 256 writes, addr 00..FF, words_loaded=256, done=1.
//  - CHECKSUM_EN: 01,0E,16,chk 18 -> done=1; chk 19 -> error=1, done=0, cpu_hold=0.
//  - start pulsed while busy -> ignored; start after done -> done cleared, new frame from BASE_ADDR.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// Shared state encodings, framing constants and state-class helpers for the program loader.
// Encodings are plain 3-bit constants so netlists and older tools see fixed codes.
package prog_loader_pkg;

  localparam int BYTE_W         = 8;
  localparam int BYTES_PER_WORD = 2;
  localparam int WORD_W         = BYTE_W * BYTES_PER_WORD;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CNT  = 3'd1;
  localparam logic [2:0] S_HI   = 3'd2;
  localparam logic [2:0] S_LO   = 3'd3;
  localparam logic [2:0] S_WR   = 3'd4;
  localparam logic [2:0] S_CHK  = 3'd5;
  localparam logic [2:0] S_DONE = 3'd6;
  localparam logic [2:0] S_ERR  = 3'd7;

  function automatic logic takes_byte(input logic [2:0] st);
    return (st == S_CNT) || (st == S_HI) || (st == S_LO) || (st == S_CHK);
  endfunction

  function automatic logic in_frame(input logic [2:0] st);
    return takes_byte(st) || (st == S_WR);
  endfunction

  function automatic logic can_start(input logic [2:0] st);
    return (st == S_IDLE) || (st == S_DONE) || (st == S_ERR);
  endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream input (valid/ready) and instruction-memory write port of the program loader.
// master = loader side, slave = UART receiver / imem / testbench side.
interface prog_loader_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);

  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic [DATA_W-1:0] imem_data;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_we;

  modport master (
    input  rx_data, rx_valid,
    output rx_ready, imem_data, imem_addr, imem_we
  );

  modport slave (
    output rx_data, rx_valid,
    input  rx_ready, imem_data, imem_addr, imem_we
  );

endinterface

// File: rtl/prog_loader_word_assembler.sv
// Holds the high byte of the word in flight and a running XOR of every payload byte.
// word = {held high byte, current input byte}; valid when the input byte is the low byte.
module word_assembler
  import prog_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              hi_load,
  input  logic              lo_load,
  input  logic [BYTE_W-1:0] byte_in,
  output logic [WORD_W-1:0] word,
  output logic [BYTE_W-1:0] xsum
);

  logic [BYTE_W-1:0] hi_q;
  logic [BYTE_W-1:0] xsum_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q   <= '0;
      xsum_q <= '0;
    end else if (clr) begin
      xsum_q <= '0;
    end else begin
      if (hi_load) begin
        hi_q <= byte_in;
      end
      if (hi_load || lo_load) begin
        xsum_q <= xsum_q ^ byte_in;
      end
    end
  end

  assign word = {hi_q, byte_in};
  assign xsum = xsum_q;

endmodule

// File: rtl/prog_loader.sv
// Loads a framed byte stream (count, then hi/lo word pairs) into imem while holding the CPU.
// imem_we one cycle after each low byte; rx_ready low in IDLE/WR/DONE/ERR. LOADER_CHECKSUM_EN adds a trailing XOR byte check.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int                ADDR_W    = 8,
  parameter int                DATA_W    = WORD_W,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  prog_loader_if.master     bus,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  localparam logic [ADDR_W:0] FULL_LEN = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE      = {{ADDR_W{1'b0}}, 1'b1};

  logic [2:0]        state;
  logic [2:0]        state_nxt;
  logic [ADDR_W:0]   frame_len;
  logic [ADDR_W:0]   wl_q;
  logic [ADDR_W:0]   wl_inc;
  logic              accept;
  logic              start_ok;
  logic              last_word;
  logic              hi_load;
  logic              lo_load;
  logic [WORD_W-1:0] asm_word;
  logic [BYTE_W-1:0] asm_xsum;
  logic [DATA_W-1:0] imem_data_q;
  logic [ADDR_W-1:0] imem_addr_q;
  logic              imem_we_q;

  assign accept    = bus.rx_valid && bus.rx_ready;
  assign start_ok  = start && can_start(state);
  assign wl_inc    = wl_q + ONE;
  assign last_word = (wl_inc == frame_len);
  assign hi_load   = accept && (state == S_HI);
  assign lo_load   = accept && (state == S_LO);

  word_assembler u_asm (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (start_ok),
    .hi_load (hi_load),
    .lo_load (lo_load),
    .byte_in (bus.rx_data),
    .word    (asm_word),
    .xsum    (asm_xsum)
  );

`ifndef LOADER_CHECKSUM_EN
  logic unused_xsum;
  assign unused_xsum = ^asm_xsum;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE, S_ERR: if (start)  state_nxt = S_CNT;
      S_CNT:                 if (accept) state_nxt = S_HI;
      S_HI:                  if (accept) state_nxt = S_LO;
      S_LO:                  if (accept) state_nxt = S_WR;
      S_WR: begin
        if (!last_word) begin
          state_nxt = S_HI;
        end else begin
`ifdef LOADER_CHECKSUM_EN
          state_nxt = S_CHK;
`else
          state_nxt = S_DONE;
`endif
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHK: if (accept) state_nxt = (bus.rx_data == asm_xsum) ? S_DONE : S_ERR;
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

  // imem outputs are registered at low-byte acceptance so they stay put until the next word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      frame_len   <= '0;
      wl_q        <= '0;
      imem_data_q <= '0;
      imem_addr_q <= '0;
      imem_we_q   <= 1'b0;
    end else begin
      state     <= state_nxt;
      imem_we_q <= 1'b0;
      if (start_ok) begin
        wl_q <= '0;
      end
      if (accept && (state == S_CNT)) begin
        frame_len <= (bus.rx_data == 8'h00) ? FULL_LEN : (ADDR_W+1)'(bus.rx_data);
      end
      if (lo_load) begin
        imem_we_q   <= 1'b1;
        imem_addr_q <= BASE_ADDR + wl_q[ADDR_W-1:0];
        imem_data_q <= asm_word;
      end
      if (state == S_WR) begin
        wl_q <= wl_inc;
      end
    end
  end

  assign bus.rx_ready  = takes_byte(state);
  assign bus.imem_data = imem_data_q;
  assign bus.imem_addr = imem_addr_q;
  assign bus.imem_we   = imem_we_q;

  assign busy         = in_frame(state);
  assign cpu_hold     = busy;
  assign done         = (state == S_DONE);
  assign error        = (state == S_ERR);
  assign words_loaded = wl_q;

endmodule
